// File: rtl/mux_n_reg_if.sv
// Stream bundle for mux_n_reg: the packed inputs, select and handshake in,
// and the registered word, error flag and handshake out.
interface mux_n_reg_if #(
  parameter int WIDTH     = 32,
  parameter int NUM_IN    = 4,
  parameter int SEL_W     = 2,
  parameter int ERR_CNT_W = 8
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;
  logic [ERR_CNT_W-1:0]    err_count;

  modport slave (
    input  in_data, sel, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid, err_count
  );

  modport master (
    output in_data, sel, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid, err_count
  );
endinterface

// File: rtl/mux_n_reg.sv
// N-way select mux with a registered valid/ready output stage and a
// 2-entry skid buffer. An out-of-range select yields a zero word with err set.
module mux_n_reg #(
  parameter int WIDTH     = 32,
  parameter int NUM_IN    = 4,
  parameter int SEL_W     = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_n_reg_if.slave   bus
);
  localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);

  logic [WIDTH-1:0]     main_data_q, main_data_d;
  logic                 main_err_q, main_err_d;
  logic                 main_valid_q, main_valid_d;
  logic [WIDTH-1:0]     skid_data_q, skid_data_d;
  logic                 skid_err_q, skid_err_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] sel_word;
  logic             sel_err;
  logic             accept;
  logic             transfer;

  // Unmatched (out-of-range) selects fall through to the all-zero default.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if ({1'b0, bus.sel} == (SEL_W+1)'(k)) sel_word = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  assign sel_err  = !({1'b0, bus.sel} < NUM_IN_L);
  assign accept   = bus.in_valid && !skid_valid_q;
  assign transfer = main_valid_q && bus.out_ready;

  always_comb begin
    main_data_d  = main_data_q;
    main_err_d   = main_err_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    skid_valid_d = skid_valid_q;
    err_cnt_d    = err_cnt_q;

    if (skid_valid_q) begin
      if (transfer) begin
        main_data_d  = skid_data_q;
        main_err_d   = skid_err_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || transfer) begin
      main_valid_d = accept;
      if (accept) begin
        main_data_d = sel_word;
        main_err_d  = sel_err;
      end
    end else if (accept) begin
      skid_data_d  = sel_word;
      skid_err_d   = sel_err;
      skid_valid_d = 1'b1;
    end

    if (accept && sel_err && (err_cnt_q != {ERR_CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_q  <= '0;
      main_err_q   <= 1'b0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      main_data_q  <= main_data_d;
      main_err_q   <= main_err_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      skid_valid_q <= skid_valid_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // in_ready comes straight from the skid flop, never from out_ready.
  assign bus.in_ready  = !skid_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_err   = main_err_q;
  assign bus.out_valid = main_valid_q;
  assign bus.err_count = err_cnt_q;
endmodule

// File: doc/mux_n_reg.md
Name: mux_n_reg

Overview:
- Parametrised N-way, WIDTH-bit select multiplexer with a registered, valid/ready-handshaked output stage.
- Generalises the 32-bit 2:1 datapath muxes to any width and input count.
- Adds defined out-of-range select handling, an error flag and a 2-entry skid buffer, so a stall on the output never drops data or creates a combinational ready path.
- Used between pipeline stages of the MIPS datapath, for example for the writeback-source, ALU-operand and forwarding selections.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of selectable inputs; legal range 2..16.
- SEL_W, 2, width of sel; must satisfy 2**SEL_W >= NUM_IN.
- ERR_CNT_W, 8, width of the saturating select-error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low.
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  index of the input to forward; sampled with in_data on acceptance.
- in_valid  input  1  upstream offers in_data/sel this cycle.
- in_ready  output  1  block can accept this cycle.
- out_data  output  WIDTH  registered selected data.
- out_err  output  1  registered flag: this output word came from an out-of-range sel.
- out_valid  output  1  out_data/out_err hold a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- err_count  output  ERR_CNT_W  saturating count of accepted out-of-range selects.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_data=0, out_err=0, out_valid=0.
  - Skid entry cleared (skid_valid=0).
  - err_count=0; in_ready=1 one gate delay after reset asserts.
- Selection, per accepted word:
  - If sel < NUM_IN, the word is in_data[sel*WIDTH +: WIDTH] and err=0.
  - If sel >= NUM_IN, the word is all-zero and err=1; X is never driven.
- Acceptance: a word is accepted when in_valid && in_ready at a rising clk edge.
- Storage:
  - Main register: out_data/out_err/out_valid.
  - Skid register: skid_data/skid_err/skid_valid.
  - in_ready = !skid_valid, a register output only; no combinational path from out_ready.
- Transfer: out_valid && out_ready at the edge. Cases per edge, A = accept, T = transfer:
  - Main empty, A: word goes to main; out_valid=1 next cycle. Latency is 1 cycle.
  - Main full, T, no A, skid empty: out_valid=0.
  - Main full, T, A, skid empty: new word to main; out_valid stays 1 (full throughput).
  - Main full, no T, A: new word to skid; skid_valid=1; in_ready=0 next cycle.
  - Skid full, T: skid moves to main; skid_valid=0. No acceptance is possible since in_ready=0.
  - Skid full, no T: everything holds.
- Ordering: words leave in acceptance order; none dropped or duplicated.
- Hold: out_data/out_err stay stable while out_valid && !out_ready.
- err_count:
  - Increments by 1 on each accepted word with err=1.
  - Saturates at 2**ERR_CNT_W-1.
  - Counts at acceptance, not at transfer.
- Changing sel or in_data without in_valid has no effect on any output.
- Reset mid-operation: any words held are discarded, outputs go to reset values immediately, and the block resumes accepting on the first edge after rst_n rises.

Test Plan:
- Reset, then single word: NUM_IN=4, in_data={32'h4,32'h3,32'h2,32'h1}, sel=2, one-cycle in_valid, out_ready=1 -> out_data=32'h3 and out_err=0 exactly one cycle later; out_valid high for one cycle.
- Streaming: sel sequence 0,1,2,3 on consecutive cycles, out_ready=1 -> out_data=1,2,3,4 back-to-back; in_ready constant 1.
- Stall: out_ready=0 while sending sel=0 then sel=1 -> main holds 32'h1, skid holds 32'h2, in_ready=0 from the 3rd cycle. Raise out_ready -> 32'h1 then 32'h2 with no loss.
- Bad select: NUM_IN=3, SEL_W=2, sel=3 accepted -> out_data=0, out_err=1, err_count=1. Then 300 bad selects with ERR_CNT_W=8 -> err_count saturates at 255.
- Async reset: drop rst_n mid-cycle with both entries full -> out_valid=0, in_ready=1 and err_count=0 immediately, without waiting for a clk edge.
- Randomised valid/ready backpressure, 1000 words, WIDTH=8, NUM_IN=5 -> output sequence equals the scoreboard-predicted sequence in acceptance order.
